// File: rtl/lc3b_types.sv
// Shared types for the victim buffer: controller states, default line type and offset width.
package lc3b_types;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP,
        ST_FETCH,
        ST_EVICT,
        ST_INSTALL
    } vstate_e;

    localparam int LINE_W_DEF = 128;
    localparam int OFFSET_W   = $clog2(LINE_W_DEF / 8);

    typedef logic [LINE_W_DEF-1:0] line_t;

    function automatic int offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/victim_lru.sv
// Full recency order over NUM_WAYS entries; age 0 is MRU, age NUM_WAYS-1 is LRU.
module victim_lru #(
    parameter int NUM_WAYS = 4,
    localparam int IDX_W = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch_i,
    input  logic [IDX_W-1:0] touch_idx_i,
    output logic [IDX_W-1:0] lru_idx_o
);

    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    logic [IDX_W-1:0] age_q [NUM_WAYS];
    logic [IDX_W-1:0] age_d [NUM_WAYS];

    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            age_d[i] = age_q[i];
            if (touch_i) begin
                if (IDX_W'(i) == touch_idx_i)
                    age_d[i] = '0;
                else if (age_q[i] < age_q[touch_idx_i])
                    age_d[i] = age_q[i] + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WAYS; i++)
                age_q[i] <= IDX_W'(NUM_WAYS - 1 - i);
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        lru_idx_o = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            if (age_q[i] == IDX_W'(NUM_WAYS - 1))
                lru_idx_o = IDX_W'(i);
    end

endmodule

// File: rtl/victim_buffer.sv
// Fully associative victim buffer between L2 and physical memory.
// Define VICTIM_DIRTY_EN to keep dirty bits and drop clean victims without write-back.
module victim_buffer
    import lc3b_types::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_read,
    input  logic              v_write,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [LINE_W-1:0] v_wdata,
    input  logic              v_wdirty,
    output logic [LINE_W-1:0] v_rdata,
    output logic              v_resp,
    output logic              p_read,
    output logic              p_write,
    output logic [ADDR_W-1:0] p_addr,
    output logic [LINE_W-1:0] p_wdata,
    input  logic [LINE_W-1:0] p_rdata,
    input  logic              p_resp
);

    localparam int OFF_W = offset_w(LINE_W);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int IDX_W = $clog2(NUM_WAYS);

`ifdef VICTIM_DIRTY_EN
    localparam bit DIRTY_EN = 1'b1;
`else
    localparam bit DIRTY_EN = 1'b0;
`endif

    vstate_e state_q, state_d;
    logic [NUM_WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q [NUM_WAYS];
    logic [TAG_W-1:0] tag_d [NUM_WAYS];
    logic [LINE_W-1:0] data_q [NUM_WAYS];
    logic [LINE_W-1:0] data_d [NUM_WAYS];
    logic [LINE_W-1:0] rdata_q, rdata_d, pwdata_q, pwdata_d;
    logic [LINE_W-1:0] req_data_q, req_data_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic req_dirty_q, req_dirty_d;
    logic [IDX_W-1:0] victim_q, victim_d;

    logic [TAG_W-1:0] in_tag;
    logic [IDX_W-1:0] hit_idx, free_idx, lru_idx, touch_idx;
    logic hit, free_any, touch, wb_need;
    logic unused_offset;

    assign in_tag = v_addr[ADDR_W-1:OFF_W];
    assign unused_offset = ^v_addr[OFF_W-1:0];
    // Without stored dirty state every line is marked dirty, so valid victims always write back.
    assign wb_need = dirty_q[lru_idx];

    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == in_tag) begin
                hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    victim_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
        .clk        (clk),
        .rst        (rst),
        .touch_i    (touch),
        .touch_idx_i(touch_idx),
        .lru_idx_o  (lru_idx)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d = tag_q;
        data_d = data_q;
        rdata_d = rdata_q;
        pwdata_d = pwdata_q;
        paddr_d = paddr_q;
        req_tag_d = req_tag_q;
        req_data_d = req_data_q;
        req_dirty_d = req_dirty_q;
        victim_d = victim_q;
        touch = 1'b0;
        touch_idx = hit_idx;
        unique case (state_q)
            ST_IDLE: begin
                req_tag_d = in_tag;
                req_data_d = v_wdata;
                req_dirty_d = DIRTY_EN ? v_wdirty : 1'b1;
                if (v_write) begin
                    if (hit) begin
                        data_d[hit_idx] = v_wdata;
                        dirty_d[hit_idx] = dirty_q[hit_idx] | req_dirty_d;
                        touch = 1'b1;
                        state_d = ST_RESP;
                    end else if (free_any) begin
                        valid_d[free_idx] = 1'b1;
                        dirty_d[free_idx] = req_dirty_d;
                        tag_d[free_idx] = in_tag;
                        data_d[free_idx] = v_wdata;
                        touch = 1'b1;
                        touch_idx = free_idx;
                        state_d = ST_RESP;
                    end else begin
                        victim_d = lru_idx;
                        if (wb_need) begin
                            paddr_d = {tag_q[lru_idx], {OFF_W{1'b0}}};
                            pwdata_d = data_q[lru_idx];
                            state_d = ST_EVICT;
                        end else begin
                            state_d = ST_INSTALL;
                        end
                    end
                end else if (v_read) begin
                    if (hit) begin
                        rdata_d = data_q[hit_idx];
                        touch = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        paddr_d = {in_tag, {OFF_W{1'b0}}};
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (p_resp) begin
                    rdata_d = p_rdata;
                    state_d = ST_IDLE;
                end
            end
            ST_EVICT: begin
                if (p_resp)
                    state_d = ST_INSTALL;
            end
            ST_INSTALL: begin
                valid_d[victim_q] = 1'b1;
                dirty_d[victim_q] = req_dirty_q;
                tag_d[victim_q] = req_tag_q;
                data_d[victim_q] = req_data_q;
                touch = 1'b1;
                touch_idx = victim_q;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            rdata_q <= '0;
            pwdata_q <= '0;
            paddr_q <= '0;
            req_tag_q <= '0;
            req_data_q <= '0;
            req_dirty_q <= 1'b0;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            rdata_q <= rdata_d;
            pwdata_q <= pwdata_d;
            paddr_q <= paddr_d;
            req_tag_q <= req_tag_d;
            req_data_q <= req_data_d;
            req_dirty_q <= req_dirty_d;
            victim_q <= victim_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        data_q <= data_d;
    end

    // A fetched line is forwarded in the same cycle the memory answers.
    assign v_resp = (state_q == ST_RESP) || (state_q == ST_FETCH && p_resp);
    assign v_rdata = (state_q == ST_FETCH && p_resp) ? p_rdata : rdata_q;
    assign p_read = (state_q == ST_FETCH);
    assign p_write = (state_q == ST_EVICT);
    assign p_addr = paddr_q;
    assign p_wdata = pwdata_q;

endmodule

// File: tb/tb_victim_buffer.sv
// Self-checking bench for victim_buffer: directed scenarios plus random traffic against a recency-queue model.
module tb_victim_buffer;

    localparam int NW = 4;
    localparam int AW = 16;
    localparam int LW = 128;

`ifdef VICTIM_DIRTY_EN
    localparam bit DEN = 1'b1;
`else
    localparam bit DEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v_read = 1'b0, v_write = 1'b0, v_wdirty = 1'b0;
    logic [AW-1:0] v_addr = '0;
    logic [LW-1:0] v_wdata = '0;
    logic [LW-1:0] v_rdata;
    logic v_resp, p_read, p_write;
    logic [AW-1:0] p_addr;
    logic [LW-1:0] p_wdata;
    logic [LW-1:0] p_rdata = '0;
    logic p_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    victim_buffer #(.NUM_WAYS(NW), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .v_read(v_read), .v_write(v_write), .v_addr(v_addr),
        .v_wdata(v_wdata), .v_wdirty(v_wdirty),
        .v_rdata(v_rdata), .v_resp(v_resp),
        .p_read(p_read), .p_write(p_write), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_rdata(p_rdata), .p_resp(p_resp)
    );

    // Model: index 0 is least recently used.
    logic [11:0] mtag[$];
    logic [LW-1:0] mdat[$];
    bit mdty[$];

    int mem_dly = 0;
    bit hold_rd = 0;

    bit b_got, b_bad;
    int b_lat, b_nev, b_kind;
    logic [AW-1:0] b_addr;
    logic [LW-1:0] b_wdat, b_mem, b_rdata;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        v_read = 0; v_write = 0; v_addr = '0; v_wdata = '0; v_wdirty = 0;
        p_resp = 0; p_rdata = '0;
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        mtag.delete(); mdat.delete(); mdty.delete();
    endtask

    task automatic bus(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [LW-1:0] wd, input bit dty);
        bit busy;
        int cnt;
        busy = 0; cnt = 0;
        v_read = rd; v_write = wr; v_addr = a; v_wdata = wd; v_wdirty = dty;
        b_got = 0; b_bad = 0; b_lat = 0; b_nev = 0; b_kind = 0;
        b_addr = '0; b_wdat = '0; b_mem = '0; b_rdata = '0;
        while (!b_got && b_lat < 100) begin
            @(posedge clk); #1;
            b_lat++;
            p_resp = 0;
            if (p_read && p_write) b_bad = 1;
            if (p_read || p_write) begin
                if (!busy) begin
                    busy = 1;
                    cnt = (mem_dly > 0) ? mem_dly : int'($urandom_range(1, 4));
                    b_nev++;
                    b_kind = p_read ? 1 : 2;
                    b_addr = p_addr;
                    b_wdat = p_wdata;
                end else begin
                    if (p_addr !== b_addr || p_wdata !== b_wdat) b_bad = 1;
                    cnt--;
                    if (cnt == 0) begin
                        p_resp = 1;
                        p_rdata = rnd_line();
                        b_mem = p_rdata;
                        busy = 0;
                    end
                end
            end
            #1;
            if (v_resp) begin
                b_got = 1;
                b_rdata = v_rdata;
            end
        end
        v_write = 0;
        if (!hold_rd) v_read = 0;
        @(posedge clk); #1;
        p_resp = 0;
    endtask

    task automatic op(input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [LW-1:0] wd, input bit dty, input string tg);
        logic [11:0] t;
        logic [AW-1:0] eaddr;
        logic [LW-1:0] ewd, erd;
        int k, ekind, elat;
        bit dw, dd;
        t = a[15:4];
        k = -1;
        foreach (mtag[i]) if (mtag[i] == t) k = i;
        ekind = 0; eaddr = '0; ewd = '0; erd = '0; elat = 1;
        dw = DEN ? dty : 1'b1;
        if (wr) begin
            if (k < 0 && mtag.size() == NW) begin
                if (!DEN || mdty[0]) begin
                    ekind = 2; eaddr = {mtag[0], 4'h0}; ewd = mdat[0]; elat = -1;
                end else begin
                    elat = 2;
                end
            end
        end else if (k < 0) begin
            ekind = 1; eaddr = {t, 4'h0}; elat = -1;
        end else begin
            erd = mdat[k];
        end
        bus(rd, wr, a, wd, dty);
        chk({tg, " resp"}, LW'(b_got), LW'(1));
        chk({tg, " pulse"}, LW'(v_resp), LW'(0));
        chk({tg, " bus"}, LW'(b_bad), LW'(0));
        chk({tg, " nphys"}, LW'(b_nev), LW'(ekind != 0));
        if (ekind != 0) begin
            chk({tg, " kind"}, LW'(b_kind), LW'(ekind));
            chk({tg, " paddr"}, LW'(b_addr), LW'(eaddr));
            if (ekind == 2) chk({tg, " pwdata"}, b_wdat, ewd);
        end
        if (elat >= 0) chk({tg, " lat"}, LW'(b_lat), LW'(elat));
        else if (mem_dly > 0) chk({tg, " lat"}, LW'(b_lat), LW'(mem_dly + ((ekind == 1) ? 1 : 3)));
        if (!wr) chk({tg, " rdata"}, b_rdata, (k >= 0) ? erd : b_mem);
        if (wr) begin
            if (k >= 0) begin
                dw = mdty[k] | dw;
                mtag.delete(k); mdat.delete(k); mdty.delete(k);
            end else if (mtag.size() == NW) begin
                void'(mtag.pop_front()); void'(mdat.pop_front()); void'(mdty.pop_front());
            end
            mtag.push_back(t); mdat.push_back(wd); mdty.push_back(dw);
        end else if (k >= 0) begin
            dd = mdty[k];
            mtag.delete(k); mdat.delete(k); mdty.delete(k);
            mtag.push_back(t); mdat.push_back(erd); mdty.push_back(dd);
        end
    endtask

    initial begin
        logic [LW-1:0] ld;
        logic [AW-1:0] ra;
        int n, sel;
        bit saw;

        do_reset();
        chk("rst v_resp", LW'(v_resp), LW'(0));
        chk("rst p_read", LW'(p_read), LW'(0));
        chk("rst p_write", LW'(p_write), LW'(0));
        chk("rst p_addr", LW'(p_addr), LW'(0));
        chk("rst p_wdata", p_wdata, LW'(0));
        chk("rst v_rdata", v_rdata, LW'(0));

        ld = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
        op(0, 1, 16'h1230, ld, 1, "w1230");
        op(1, 0, 16'h1230, '0, 0, "r1230");

        mem_dly = 5;
        op(1, 0, 16'h4000, '0, 0, "cold4000");
        op(1, 0, 16'h4000, '0, 0, "again4000");
        mem_dly = 3;

        do_reset();
        for (int i = 0; i < 4; i++) op(0, 1, AW'(i * 16), rnd_line(), 1, "fillD");
        op(1, 0, 16'h0000, '0, 0, "touch0");
        op(0, 1, 16'h0040, rnd_line(), 1, "evictD");
        chk("evict addr", LW'(b_addr), LW'(16'h0010));

        do_reset();
        for (int i = 0; i < 4; i++) op(0, 1, AW'(i * 16), rnd_line(), 0, "fillC");
        op(1, 0, 16'h0000, '0, 0, "touchC");
        op(0, 1, 16'h0040, rnd_line(), 0, "evictC");
        op(1, 0, 16'h0010, '0, 0, "gone0010");

        do_reset();
        hold_rd = 1;
        ld = 128'hC0DE_C0DE_1111_2222_3333_4444_5555_6666;
        op(1, 1, 16'h2000, ld, 1, "both_w");
        hold_rd = 0;
        op(1, 0, 16'h2000, '0, 0, "both_r");

        do_reset();
        for (int i = 0; i < 4; i++) op(0, 1, AW'(16'h0100 * i), rnd_line(), 1, "fillR");
        v_write = 1; v_addr = 16'h0500; v_wdata = rnd_line(); v_wdirty = 1;
        n = 0;
        while (!p_write && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("evict seen", LW'(p_write), LW'(1));
        v_write = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        mtag.delete(); mdat.delete(); mdty.delete();
        chk("midrst v_resp", LW'(v_resp), LW'(0));
        chk("midrst p_write", LW'(p_write), LW'(0));
        chk("midrst p_read", LW'(p_read), LW'(0));
        chk("midrst p_addr", LW'(p_addr), LW'(0));
        chk("midrst p_wdata", p_wdata, LW'(0));
        chk("midrst v_rdata", v_rdata, LW'(0));
        p_resp = 1; p_rdata = rnd_line();
        saw = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (v_resp || p_write || p_read) saw = 1;
            @(posedge clk); #1;
            p_resp = 0;
        end
        chk("late p_resp", LW'(saw), LW'(0));
        for (int i = 0; i < 4; i++) op(1, 0, AW'(16'h0100 * i), '0, 0, "postrst");

        do_reset();
        mem_dly = 0;
        for (int it = 0; it < 300; it++) begin
            sel = int'($urandom_range(0, 9));
            ra = {12'($urandom_range(0, 5)) * 12'h101, 4'($urandom)};
            if (sel < 4) op(1, 0, ra, '0, 0, "rnd_rd");
            else if (sel < 9) op(0, 1, ra, rnd_line(), 1'($urandom), "rnd_wr");
            else op(1, 1, ra, rnd_line(), 1'($urandom), "rnd_both");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/victim_buffer.md
VICTIM_BUFFER -- requirements
Module: victim_buffer

Interface
REQ-001 Parameter NUM_WAYS, default 4, number of fully associative entries; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 16, byte address width.
REQ-003 Parameter LINE_W, default 128, line width in bits; offset width = log2(LINE_W/8).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 v_read, v_write  in  1 each  L2 requests, held until v_resp.
REQ-007 v_addr  in  ADDR_W  L2 request address.
REQ-008 v_wdata  in  LINE_W  victim line from L2.
REQ-009 v_wdirty  in  1  victim line dirty flag.
REQ-010 v_rdata  out  LINE_W  line returned to L2.
REQ-011 v_resp  out  1  one-cycle completion pulse to L2.
REQ-012 p_read, p_write  out  1 each  physical memory requests.
REQ-013 p_addr  out  ADDR_W  physical address, offset bits zero.
REQ-014 p_wdata  out  LINE_W  write-back line.
REQ-015 p_rdata  in  LINE_W  line from physical memory.
REQ-016 p_resp  in  1  physical completion pulse.

Function
REQ-017 Tag = v_addr upper bits above offset; hit = any valid entry with equal tag; at most one entry per tag.
REQ-018 Read hit: v_rdata = entry data, v_resp pulses exactly 1 cycle after v_read is sampled in IDLE; entry becomes MRU.
REQ-019 Read miss: p_read asserts with p_addr = line address; on p_resp, v_rdata = p_rdata and v_resp pulse the same cycle; no allocation.
REQ-020 Write hit: overwrite data and OR in dirty, entry becomes MRU, v_resp 1 cycle later; no physical traffic.
REQ-021 Write miss with a free entry: allocate the lowest-index invalid entry, MRU, v_resp 1 cycle later.
REQ-022 Write miss, all valid: LRU entry is the victim; if it must be written back (REQ-032), p_write asserts with its address/data until p_resp, then install and v_resp on the next cycle.
REQ-023 States: IDLE, RESP, FETCH, EVICT, INSTALL; IDLE->RESP on hit or write-to-free; IDLE->FETCH on read miss; IDLE->EVICT or INSTALL on full write miss; FETCH->IDLE on p_resp; EVICT->INSTALL on p_resp; INSTALL->RESP; RESP->IDLE.
REQ-024 v_resp is high in exactly one cycle per request; a request still high in IDLE after v_resp is treated as new.
REQ-025 v_read and v_write both high: v_write is served first; v_read is served as a separate request afterwards.
REQ-026 p_read and p_write are never high together; p_addr/p_wdata are stable while either is high.
REQ-027 LRU: a full recency order is kept; every hit or install makes that entry MRU; invalid entries never affect victim choice.
REQ-028 Requests arriving outside IDLE are ignored until the state returns to IDLE.

Reset
REQ-029 After rst: state IDLE; all valid and dirty bits clear; LRU order = index order (entry 0 is LRU).
REQ-030 Reset values: v_resp, p_read, p_write = 0; p_addr, p_wdata, v_rdata = 0.
REQ-031 rst during FETCH or EVICT abandons the transaction; no v_resp is issued; a late p_resp is ignored.

Configuration
REQ-032 Macro VICTIM_DIRTY_EN: when defined, dirty bits are stored and a clean LRU victim is dropped without p_write; when undefined, v_wdirty is ignored and every valid victim is written back.

Structure
REQ-033 lc3b_types holds the victim state enum, the line typedef and the offset-width constant.
REQ-034 Recency tracking is one sub-module, victim_lru (inputs: touch, touch index; output: LRU index), sized by NUM_WAYS.

Verification
REQ-035 After reset, write 0x1230 with data A -> v_resp at cycle +1, no p_write; read 0x1230 -> v_rdata = A at cycle +1.
REQ-036 Read 0x4000 cold -> p_read with p_addr 0x4000; p_resp with data B after 5 cycles -> v_resp and v_rdata = B the same cycle; re-read misses again.
REQ-037 NUM_WAYS=4: write 0x0000, 0x0010, 0x0020, 0x0030, read 0x0000, write 0x0040 -> p_write with p_addr 0x0010.
REQ-038 With VICTIM_DIRTY_EN: same sequence, all writes v_wdirty=0 -> no p_write, 0x0010 then misses; without the macro -> p_write issued.
REQ-039 v_read and v_write both high for 0x2000 -> write served first, then read returns the written data.
REQ-040 rst pulsed mid-EVICT -> no v_resp; later p_resp ignored; all entries invalid; outputs zero.
